// File: rtl/bit_serializer_piso.sv
// -----------------------------------------------------------------------------
// bit_serializer_piso
//   Parallel-in / serial-out stage that feeds the serial-input sequence
//   detectors. A WIDTH-bit word is accepted over a valid/ready handshake and
//   shifted out MSB-first at one bit per clk on ser_out. The line idles at 0,
//   so an idle stage looks to a detector like a stream of zeros.
//
//   Optional feature macro: SER_PARITY_EN
//     defined   -> one even-parity bit (^load_data, captured at the transfer)
//                  follows the LSB; a frame is WIDTH+1 bits and done/reload
//                  move to the parity-bit cycle.
//     undefined -> frame is WIDTH bits; no parity logic exists.
//
//   Reset: rst is asynchronous and active-low (rst==0 resets).
// -----------------------------------------------------------------------------
module bit_serializer_piso #(
  parameter int WIDTH = 8                      // data bits per word, >= 2
) (
  input  logic             clk,
  input  logic             rst,                // async, active-low
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  // ---------------------------------------------------------------------------
  // Frame geometry
  // ---------------------------------------------------------------------------
`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;            // data bits + trailing parity
`else
  localparam int NBITS = WIDTH;                // data bits only
`endif

  // Counter is sized for WIDTH+1 in both builds so it can always reach the
  // parity slot; in the plain build the top value is simply never used.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  // FSM encoding kept as plain constants so the state vector is visible as a
  // bare vector in older tools and netlists.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q,   state_d;
  logic [NBITS-1:0] shreg_q,   shreg_d;       // MSB of the register is on the wire
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;     // index of the bit currently on ser_out

  logic             shifting;
  logic             last_bit;
  logic             xfer;
  logic [NBITS-1:0] load_word;

  // ---------------------------------------------------------------------------
  // Handshake decode: ready depends on state/bit_cnt only, never on load_valid,
  // so upstream can never form a combinational loop through this stage.
  // ---------------------------------------------------------------------------
  assign shifting   = (state_q == ST_SHIFT);
  assign last_bit   = shifting && (bit_cnt_q == LAST_CNT);
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign xfer       = load_valid && load_ready;

  // Frame to load on a transfer. Only consumed when xfer is high, so an X on
  // load_data between transfers never reaches the state registers.
`ifdef SER_PARITY_EN
  assign load_word = {load_data, ^load_data};
`else
  assign load_word = load_data;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic: load, shift, or drain back to idle
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d   = ST_SHIFT;
          shreg_d   = load_word;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        if (xfer) begin
          // Reload on the last-bit cycle: the next frame's MSB follows the
          // current final bit with no gap.
          state_d   = ST_SHIFT;
          shreg_d   = load_word;
          bit_cnt_d = '0;
        end else if (last_bit) begin
          // Clearing the shifter guarantees the idle line reads 0 even if a
          // stale bit were somehow left behind.
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else begin
          shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers, asynchronously cleared
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the shifter is reset along with the control state because its MSB
    // drives ser_out directly; a mid-word reset must force the line to 0 at once.
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, so they fall with the async reset
  // ---------------------------------------------------------------------------
  assign ser_out   = shifting && shreg_q[NBITS-1];
  assign ser_valid = shifting;
  assign busy      = shifting;
  assign done      = last_bit;

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  // The line is quiet whenever no frame is in flight.
  a_idle_quiet : assert property (@(posedge clk) disable iff (!rst)
    !busy |-> (!ser_out && !ser_valid && !done));

  // A transfer always starts a fresh frame at bit 0 on the next cycle.
  a_xfer_starts : assert property (@(posedge clk) disable iff (!rst)
    xfer |=> (busy && ser_valid && bit_cnt_q == '0));

  // Without a reload, the stage goes idle right after the final bit.
  a_done_drains : assert property (@(posedge clk) disable iff (!rst)
    (done && !load_valid) |=> !busy);

  // Mid-frame the stage refuses new words.
  a_busy_not_ready : assert property (@(posedge clk) disable iff (!rst)
    (busy && !done) |-> !load_ready);

endmodule

// File: tb/tb_bit_serializer_piso.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer_piso
//   Directed bench for bit_serializer_piso (WIDTH=8). Expected frames are
//   built from the literal test words; the parity bit is appended when the
//   bench is compiled with SER_PARITY_EN, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_bit_serializer_piso;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int tests_run    = 0;
  int tests_failed = 0;

  bit_serializer_piso #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial frame for a word, first bit at the top.
  function automatic logic [NB-1:0] frame(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Load one word from idle and check every bit of the frame plus the return
  // to idle. Vector layout: {ser_out, ser_valid, busy, done, load_ready}.
  // ---------------------------------------------------------------------------
  task automatic send_and_check(input logic [WIDTH-1:0] d, input string tag);
    logic [NB-1:0] f;
    logic [4:0]    exp_v;
    logic [4:0]    obs_v;
    f = frame(d);
    load_valid = 1'b1;
    load_data  = d;
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_load: got %b expected 1", tag, load_ready);
    end
    step();
    load_valid = 1'b0;
    load_data  = 'x;
    for (int i = 0; i < NB; i++) begin
      exp_v = {f[NB-1-i], 1'b1, 1'b1, (i == NB-1), (i == NB-1)};
      obs_v = {ser_out, ser_valid, busy, done, load_ready};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL %s bit%0d: got %b expected %b", tag, i, obs_v, exp_v);
      end
      step();
    end
    exp_v = 5'b00001;
    obs_v = {ser_out, ser_valid, busy, done, load_ready};
    tests_run++;
    if (obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL %s idle_after: got %b expected %b", tag, obs_v, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reset held two cycles while load_valid toggles: nothing accepted.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] obs4;
    logic [4:0] obs_v;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    #1 rst     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = ~load_valid;
      load_data  = 8'hFF;
      step();
      obs4 = {ser_out, ser_valid, busy, done};
      tests_run++;
      if (obs4 !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got %b expected 0000", i, obs4);
      end
    end
    rst        = 1'b1;
    load_valid = 1'b0;
    step();
    obs_v = {ser_out, ser_valid, busy, done, load_ready};
    tests_run++;
    if (obs_v !== 5'b00001) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected 00001", obs_v);
    end
  endtask

  task automatic test_single_word();
    send_and_check(8'b1001_0110, "single_96");
  endtask

  // ---------------------------------------------------------------------------
  // 8'hA5 then 8'h3C with load_valid held: gap-free 2*NB bit stream.
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [2*NB-1:0] s;
    logic [4:0]      exp_v;
    logic [4:0]      obs_v;
    logic            last;
    s = {frame(8'hA5), frame(8'h3C)};
    load_valid = 1'b1;
    load_data  = 8'hA5;
    step();
    for (int i = 0; i < 2*NB; i++) begin
      if (i == 0) load_data = 8'h3C;
      if (i == NB) begin
        load_valid = 1'b0;
        load_data  = 'x;
      end
      last  = ((i % NB) == NB-1);
      exp_v = {s[2*NB-1-i], 1'b1, 1'b1, last, last};
      obs_v = {ser_out, ser_valid, busy, done, load_ready};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL b2b bit%0d: got %b expected %b", i, obs_v, exp_v);
      end
      step();
    end
    obs_v = {ser_out, ser_valid, busy, done, load_ready};
    tests_run++;
    if (obs_v !== 5'b00001) begin
      tests_failed++;
      $display("FAIL b2b idle_after: got %b expected 00001", obs_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pulse 8'hFF during bit 3 of 8'h90: must be refused and leave no trace.
  // ---------------------------------------------------------------------------
  task automatic test_load_while_busy();
    logic [NB-1:0] f;
    logic [4:0]    exp_v;
    logic [4:0]    obs_v;
    f = frame(8'h90);
    load_valid = 1'b1;
    load_data  = 8'h90;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == 3) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
      end
      if (i == 4) begin
        load_valid = 1'b0;
        load_data  = 'x;
      end
      exp_v = {f[NB-1-i], 1'b1, 1'b1, (i == NB-1), (i == NB-1)};
      obs_v = {ser_out, ser_valid, busy, done, load_ready};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL busy_load bit%0d: got %b expected %b", i, obs_v, exp_v);
      end
      step();
    end
    obs_v = {ser_out, ser_valid, busy, done, load_ready};
    tests_run++;
    if (obs_v !== 5'b00001) begin
      tests_failed++;
      $display("FAIL busy_load idle_after: got %b expected 00001", obs_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Async reset during bit 4 of 8'hC3: outputs drop before the next edge,
  // no done afterwards, and the next word starts cleanly at its MSB.
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_word();
    logic [NB-1:0] f;
    logic [4:0]    exp_v;
    logic [4:0]    obs_v;
    logic [3:0]    obs4;
    f = frame(8'hC3);
    load_valid = 1'b1;
    load_data  = 8'hC3;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_v = {f[NB-1-i], 1'b1, 1'b1, 1'b0, 1'b0};
      obs_v = {ser_out, ser_valid, busy, done, load_ready};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL mid_reset pre bit%0d: got %b expected %b", i, obs_v, exp_v);
      end
      if (i < 4) step();
    end
    #2 rst = 1'b0;
    #1;
    obs4 = {ser_out, ser_valid, busy, done};
    tests_run++;
    if (obs4 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset immediate: got %b expected 0000", obs4);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs4 = {ser_out, ser_valid, busy, done};
      tests_run++;
      if (obs4 !== 4'b0000) begin
        tests_failed++;
        $display("FAIL mid_reset after cyc%0d: got %b expected 0000", i, obs4);
      end
    end
    send_and_check(8'hC3, "mid_reset_reload");
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    send_and_check(8'h07, "parity_07");
    send_and_check(8'h03, "parity_03");
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_word();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
